t03_ssdec_scan: RTL and testbench

Time-multiplexed driver for a bank of NUM_DIGITS seven-segment digits sharing one segment bus. It latches a packed hex value, per-digit decimal points and per-digit enables, double-buffers them so updates never tear mid-frame, and scans one digit at a time with an anti-ghosting blank slot. It sits between the team's status/debug registers and the board display pins, replacing per-digit static decoders.

---
 rtl/t03_ssdec_pkg.sv | 18 +
 rtl/t03_ssdec_scan_tick.sv | 45 ++++
 rtl/t03_ssdec_scan.sv | 192 +++++++++++++++++++
 tb/tb_t03_ssdec_scan.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/t03_ssdec_pkg.sv
// Shared types and the hex-to-seven-segment map for the scanned display driver.
package t03_ssdec_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SegBlank = 8'h00;

    // Index 0 is the rightmost entry; bit 7 (dp) is always clear here.
    localparam logic [15:0][7:0] HexSegTable = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h67, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return HexSegTable[nib];
    endfunction

endpackage

// File: rtl/t03_ssdec_scan_tick.sv
// Scan timebase: per-slot prescaler and digit index, flagging slot start and frame wrap.
module t03_ssdec_scan_tick #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned IdxW       = 2
) (
    input  logic            clk,
    input  logic            nrst,
    output logic [IdxW-1:0] index,
    output logic            slot_start,
    output logic            frame_wrap
);

    localparam int unsigned PresW = $clog2(SCAN_DIV);

    logic [PresW-1:0] presc_q, presc_d;
    logic [IdxW-1:0]  index_q, index_d;
    logic             term_cnt;
    logic             last_digit;

    always_comb begin
        term_cnt   = (presc_q == PresW'(SCAN_DIV - 1));
        last_digit = (index_q == IdxW'(NUM_DIGITS - 1));
        presc_d    = term_cnt ? '0 : presc_q + 1'b1;
        index_d    = index_q;
        if (term_cnt) begin
            index_d = last_digit ? '0 : index_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q <= '0;
            index_q <= '0;
        end else begin
            presc_q <= presc_d;
            index_q <= index_d;
        end
    end

    assign index      = index_q;
    assign slot_start = (presc_q == '0);
    assign frame_wrap = term_cnt && last_digit;

endmodule

// File: rtl/t03_ssdec_scan.sv
// Double-buffered, time-multiplexed seven-segment driver with a blank slot per digit.
// Optional blink support is built when T03_SSDEC_SCAN_BLINK_EN is defined.
module t03_ssdec_scan
    import t03_ssdec_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [IdxW-1:0] index;
    logic            slot_start;
    logic            frame_wrap;
    logic            blink_sup;

    t03_ssdec_scan_tick #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .IdxW       (IdxW)
    ) u_tick (
        .clk        (clk),
        .nrst       (nrst),
        .index      (index),
        .slot_start (slot_start),
        .frame_wrap (frame_wrap)
    );

    logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d, act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic                    pending_q, pending_d;

    // Active set only changes at the frame boundary so a frame never mixes old and new data.
    always_comb begin
        sh_value_d  = sh_value_q;
        sh_dp_d     = sh_dp_q;
        sh_en_d     = sh_en_q;
        act_value_d = act_value_q;
        act_dp_d    = act_dp_q;
        act_en_d    = act_en_q;
        pending_d   = pending_q;
        if (frame_wrap && pending_q) begin
            act_value_d = sh_value_q;
            act_dp_d    = sh_dp_q;
            act_en_d    = sh_en_q;
            pending_d   = 1'b0;
        end
        if (load) begin
            sh_value_d = value;
            sh_dp_d    = dp_in;
            sh_en_d    = digit_en;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh_value_q  <= '0;
            sh_dp_q     <= '0;
            sh_en_q     <= '0;
            act_value_q <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
            pending_q   <= 1'b0;
        end else begin
            sh_value_q  <= sh_value_d;
            sh_dp_q     <= sh_dp_d;
            sh_en_q     <= sh_en_d;
            act_value_q <= act_value_d;
            act_dp_q    <= act_dp_d;
            act_en_q    <= act_en_d;
            pending_q   <= pending_d;
        end
    end

`ifdef T03_SSDEC_SCAN_BLINK_EN
    localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_DIGITS-1:0] sh_bm_q, sh_bm_d, act_bm_q, act_bm_d;
    logic [FcW-1:0]        frame_cnt_q, frame_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic                  bm_bit;

    always_comb begin
        sh_bm_d     = sh_bm_q;
        act_bm_d    = act_bm_q;
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_wrap) begin
            if (pending_q) begin
                act_bm_d = sh_bm_q;
            end
            if (frame_cnt_q == FcW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        if (load) begin
            sh_bm_d = blink_mask;
        end
        bm_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IdxW'(i)) begin
                bm_bit = act_bm_q[i];
            end
        end
        blink_sup = bm_bit && !blink_on_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh_bm_q     <= '0;
            act_bm_q    <= '0;
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            sh_bm_q     <= sh_bm_d;
            act_bm_q    <= act_bm_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`else
    // Pin-compatible only: blink inputs are accepted and ignored.
    localparam int unsigned UnusedBlinkFrames = BLINK_FRAMES;
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_sup    = 1'b0;
`endif

    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q;
    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            nib;
    logic                  dp_bit;
    logic                  en_bit;

    always_comb begin
        sel    = '0;
        nib    = '0;
        dp_bit = 1'b0;
        en_bit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IdxW'(i)) begin
                sel[i] = 1'b1;
                nib    = act_value_q[4*i +: 4];
                dp_bit = act_dp_q[i];
                en_bit = act_en_q[i];
            end
        end
        seg_d = SegBlank;
        an_d  = '0;
        // First cycle of every slot stays dark so the previous digit cannot ghost.
        if (!slot_start && en_bit && !blink_sup) begin
            seg_d = hex_to_seg(nib) | {dp_bit, 7'b0};
            an_d  = sel;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seg_q        <= SegBlank;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_wrap;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_t03_ssdec_scan.sv
// Bench for t03_ssdec_scan: frame-arithmetic reference model plus directed literal checks.
module tb_t03_ssdec_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  blink_mask = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_on  = 1'b0;

    t03_ssdec_scan #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    // Reference model: counters derived from edge count since reset.
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int unsigned e;
    int unsigned mp, md, mf;
    logic [15:0] sh_v, ac_v;
    logic [3:0]  sh_dp, ac_dp, sh_en, ac_en, sh_bm, ac_bm;
    logic        pend, blink_off, lit;
    logic [7:0]  exp_seg = '0;
    logic [3:0]  exp_an = '0;
    logic        exp_fd = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            e = 0; pend = 1'b0;
            sh_v = '0; ac_v = '0; sh_dp = '0; ac_dp = '0;
            sh_en = '0; ac_en = '0; sh_bm = '0; ac_bm = '0;
            exp_seg = '0; exp_an = '0; exp_fd = 1'b0;
        end else begin
            mp = e % SD;
            md = (e / SD) % ND;
            mf = e / FRAME;
`ifdef T03_SSDEC_SCAN_BLINK_EN
            blink_off = ((mf / BF) % 2) == 1;
`else
            blink_off = 1'b0;
`endif
            lit     = (mp != 0) && ac_en[md] && !(blink_off && ac_bm[md]);
            exp_fd  = (e % FRAME) == FRAME - 1;
            exp_an  = lit ? (4'b0001 << md) : 4'b0000;
            exp_seg = lit ? {ac_dp[md], hex_tab[ac_v[4*md +: 4]]} : 8'h00;
            if (exp_fd && pend) begin
                ac_v = sh_v; ac_dp = sh_dp; ac_en = sh_en; ac_bm = sh_bm; pend = 1'b0;
            end
            if (load) begin
                sh_v = value; sh_dp = dp_in; sh_en = digit_en; sh_bm = blink_mask; pend = 1'b1;
            end
            e++;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_seg", seg, exp_seg);
            check("model_an", an, exp_an);
            check("model_fd", frame_done, exp_fd);
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                           input logic [3:0] bm);
        @(negedge clk);
        value = v; dp_in = dp; digit_en = en; blink_mask = bm; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 40);
        check(name, frame_done, 1);
    endtask

    logic [7:0] lit_seg [4] = '{8'h71, 8'hCF, 8'h77, 8'h06};
`ifdef T03_SSDEC_SCAN_BLINK_EN
    bit blink_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    bit blink_pat [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    initial begin
        int k;
        int nlit;
        repeat (3) @(negedge clk);
        check("reset_seg", seg, 0);
        check("reset_an", an, 0);
        check("reset_fd", frame_done, 0);
        nrst = 1'b1;
        cmp_on = 1'b1;
        repeat (3) @(negedge clk);

        // Full frame of 1A3F with dp on digit 1.
        do_load(16'h1A3F, 4'b0010, 4'hF, 4'h0);
        wait_fd("fd_after_load1");
        for (int dg = 0; dg < 4; dg++) begin
            @(negedge clk);
            check("blank_slot", {an, seg}, 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("digit_an", an, 4'b0001 << dg);
                check("digit_seg", seg, lit_seg[dg]);
            end
        end
        check("fd_period_16", frame_done, 1);
        @(negedge clk);
        check("fd_one_wide", frame_done, 0);

        // Mid-frame load must not disturb the current frame.
        do_load(16'h0000, 4'h0, 4'hF, 4'h0);
        k = 0;
        while (an !== 4'b0100 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("old_value_holds", seg, 8'h77);
        wait_fd("fd_after_zero_load");
        repeat (2) @(negedge clk);
        check("zero_an", an, 4'b0001);
        check("zero_seg", seg, 8'h3F);

        // Load pending data, then load again exactly on the boundary cycle.
        wait_fd("fd_before_boundary_load");
        do_load(16'h2222, 4'h0, 4'hF, 4'h0);
        repeat (13) @(negedge clk);
        value = 16'h5555;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("fd_at_boundary_load", frame_done, 1);
        repeat (2) @(negedge clk);
        check("prev_shadow_an", an, 4'b0001);
        check("prev_shadow_seg", seg, 8'h5B);
        repeat (16) @(negedge clk);
        check("boundary_load_next_frame", seg, 8'h6D);

        // Disabled digits stay dark.
        do_load(16'h1234, 4'h0, 4'b0101, 4'h0);
        wait_fd("fd_after_en_load");
        nlit = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (an[1] || an[3]) nlit++;
            if (c == 6) check("disabled_slot", {an, seg}, 0);
            if (c == 10) begin
                check("enabled_an", an, 4'b0100);
                check("enabled_seg", seg, 8'h5B);
            end
        end
        check("disabled_never_on", nlit, 0);

        // Asynchronous reset while a digit is lit.
        do_load(16'h8888, 4'h0, 4'hF, 4'b0001);
        wait_fd("fd_before_reset");
        repeat (6) @(negedge clk);
        check("pre_reset_lit", an, 4'b0010);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_seg", seg, 0);
        check("async_rst_an", an, 0);
        check("async_rst_fd", frame_done, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_dark", an, 0);
        @(negedge clk);
        nrst = 1'b1;
        do_load(16'h8888, 4'h0, 4'hF, 4'b0001);
        k = 0;
        nlit = 0;
        do begin
            @(negedge clk);
            k++;
            if (an !== 4'b0000) nlit++;
        end while (frame_done !== 1'b1 && k < 40);
        check("dark_until_boundary", nlit, 0);
        check("first_fd_after_reset", frame_done, 1);

        // Frames 1..6 after reset: digit 0 follows the blink phase, digit 1 always lit.
        for (int j = 0; j < 6; j++) begin
            repeat (2) @(negedge clk);
            check("blink_digit0", an, blink_pat[j] ? 4'b0001 : 4'b0000);
            repeat (4) @(negedge clk);
            check("blink_digit1_an", an, 4'b0010);
            check("blink_digit1_seg", seg, 8'h7F);
            repeat (10) @(negedge clk);
        end

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
